// File: rtl/fwd_hazard_if.sv
// Operand-forwarding / hazard bus between the ID/EX register, the EX operand muxes and the
// pipeline stall control.
interface fwd_hazard_if #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned STAT_W     = 16
);
  logic [NUM_SRC*REG_AW-1:0]    ex_src_addr;
  logic [NUM_SRC-1:0]           ex_src_used;
  logic [FWD_STAGES*REG_AW-1:0] stg_rd;
  logic [FWD_STAGES-1:0]        stg_regwrite;
  logic [FWD_STAGES-1:0]        stg_is_load;
  logic                         flush;
  logic                         clr_stats;
  logic [NUM_SRC*SEL_W-1:0]     fwd_sel;
  logic                         stall;
  logic [STAT_W-1:0]            stall_count;

  modport master (
    output ex_src_addr, ex_src_used, stg_rd, stg_regwrite, stg_is_load, flush, clr_stats,
    input  fwd_sel, stall, stall_count
  );

  modport slave (
    input  ex_src_addr, ex_src_used, stg_rd, stg_regwrite, stg_is_load, flush, clr_stats,
    output fwd_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX-stage RAW forwarding with multi-cycle load-use stall generation and a saturating
// stall-cycle statistic.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT   = 2,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned STAT_W     = 16
) (
  input logic        clk,
  input logic        rst,
  fwd_hazard_if.slave bus
);

  localparam int unsigned CntW = $clog2(FWD_STAGES) + 1;

  typedef enum logic {StIdle, StStall} fsmState_e;

  fsmState_e                stateQ, stateD;
  logic [CntW-1:0]          cntQ, cntD;
  logic [CntW-1:0]          waitReq;
  logic [NUM_SRC*SEL_W-1:0] selRaw;
  logic                     hazard;
  logic                     stallInt;
  logic                     found;
  logic [REG_AW-1:0]        srcAddr;
  logic [REG_AW-1:0]        rdAddr;
  logic [STAT_W-1:0]        statQ;

  // Nearest matching stage wins per operand; the required wait is the max over operands.
  always_comb begin
    selRaw  = '0;
    waitReq = '0;
    found   = 1'b0;
    srcAddr = '0;
    rdAddr  = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      found   = 1'b0;
      srcAddr = bus.ex_src_addr[i*REG_AW +: REG_AW];
      for (int k = 0; k < int'(FWD_STAGES); k++) begin
        rdAddr = bus.stg_rd[k*REG_AW +: REG_AW];
        if (!found && bus.ex_src_used[i] && bus.stg_regwrite[k] &&
            (rdAddr != '0) && (rdAddr == srcAddr)) begin
          found = 1'b1;
          selRaw[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          if (bus.stg_is_load[k] && (k < int'(LOAD_LAT) - 1) &&
              (CntW'(int'(LOAD_LAT) - 1 - k) > waitReq)) begin
            waitReq = CntW'(int'(LOAD_LAT) - 1 - k);
          end
        end
      end
    end
  end

  assign hazard   = (waitReq != '0);
  assign stallInt = !rst && ((stateQ == StStall) || hazard);

  assign bus.stall       = stallInt;
  assign bus.fwd_sel     = (rst || stallInt) ? '0 : selRaw;
  assign bus.stall_count = statQ;

  // IDLE covers the first stall cycle combinationally; STALL counts down the remaining W-1.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    if (bus.flush) begin
      stateD = StIdle;
      cntD   = '0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (hazard && (waitReq > CntW'(1))) begin
            stateD = StStall;
            cntD   = waitReq - CntW'(2);
          end
        end
        StStall: begin
          if (cntQ == '0) begin
            stateD = StIdle;
          end else begin
            cntD = cntQ - CntW'(1);
          end
        end
        default: begin
          stateD = StIdle;
          cntD   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statQ <= '0;
    end else if (bus.clr_stats) begin
      statQ <= '0;
    end else if (stallInt && (statQ != '1)) begin
      statQ <= statQ + STAT_W'(1);
    end
  end

endmodule
